io_gpio: RTL and testbench
==========================

# io_gpio

Parametrised multi-channel GPIO peripheral on the CPU register bus; successor to the single-port input/output/IRQ block. Each channel has per-bit direction, synchronised inputs, atomic output toggle, and per-bit IRQ with level/edge and polarity selection and sticky write-1-to-clear status. It sits on the shared address/data bus and drives `take_controlr_o`/`take_controlw_o` to claim cycles for the read/write mux.

## Interface
- `BaseAddress`, 0: first register address.
- `address_width`, 16: bus address width.
- `data_width`, 8: bits per channel and bus data width.
- `Address_Wording`, 1: address stride between registers.
- `NumChannels`, 2: channel count, 1..8.
- `SyncStages`, 2: input synchroniser depth, at least 2.
- `clk_i` in 1: the single clock.
- `reset_ni` in 1: reset, asynchronous assert, active-low.
- `address_i` in address_width: bus address.
- `data_i` in data_width: write data.
- `data_o` out data_width: registered read data.
- `rd_wr_i` in 1: 0 = read, 1 = write.
- `take_controlr_o` out 1: read address decoded this block.
- `take_controlw_o` out 1: write address decoded this block.
- `irq_o` out 1: OR of enabled pending status, all channels.
- `gpio_i` in NumChannels*data_width: pad inputs, asynchronous; channel c = bits [c*data_width +: data_width].
- `gpio_o` out NumChannels*data_width: output values.
- `gpio_oe_o` out NumChannels*data_width: output enables; equals DIR.

## Operation
- **Register addressing.** Channel c, offset r: BaseAddress + (c*8 + r)*Address_Wording.
- **Register map:**
  - 0 IN (RO): synchronised inputs.
  - 1 OUT (RW).
  - 2 DIR (RW): 1 = output.
  - 3 IRQ_EN (RW).
  - 4 IRQ_MODE (RW): 0 = level, 1 = edge.
  - 5 IRQ_POL (RW): 0 = high/rising, 1 = low/falling.
  - 6 IRQ_STATUS (RO, W1C).
  - 7 OUT_TGL (WO): OUT ^= data_i.
- **Reads.** Any decoded read offset 0–6 returns the register and sets `take_controlr_o`=1. Offset 7 and undecoded addresses return 0 with `take_controlr_o`=0.
- **Writes.** Writes to offsets 1–7 set `take_controlw_o`=1. Writes to IN and undecoded addresses are ignored with `take_controlw_o`=0.
- **IRQ_STATUS clear.** A write clears every status bit where data_i=1.
- **Event detection, per bit.** s = synchronised input, p = s delayed one cycle.
  - Level mode event: s ^ POL.
  - Edge mode event: (s & ~p) when POL=0, (~s & p) when POL=1.
- **Status latching.** Status latches events regardless of IRQ_EN.
- **irq_o.** `irq_o` = |(STATUS & IRQ_EN) over all channels, registered.
- **Simultaneous event and W1C on one bit.** Set wins.
- **Level mode re-set.** Status re-sets on the next cycle while the level persists.
- **Arm counter.** Counts SyncStages+1 cycles after reset release. Events are masked until it saturates, which suppresses spurious edges or levels from synchroniser fill.
- **Reset.** All registers, synchroniser and p flops, arm counter, `data_o`, `take_controlr_o`, `take_controlw_o`, `irq_o`, `gpio_o` and `gpio_oe_o` go to 0 immediately on `reset_ni` low. Reset mid-operation discards pending status.

## Timing
- **Read.** Address presented at edge N; `data_o`/`take_controlr_o` are valid after edge N+1 and hold while the address is held.
- **Write.** Register updates at edge N+1. `gpio_o` reflects OUT/OUT_TGL after N+1; `take_controlw_o` pulses one cycle.
- **Input path.** A `gpio_i` change is visible in IN after SyncStages edges. STATUS sets on edge SyncStages+1 and `irq_o` on edge SyncStages+2.
- **Clear to irq_o.** A W1C write at edge N drops `irq_o` at N+2 if no other enabled status remains.
- **Enable with pending status.** Writing IRQ_EN over already-set STATUS raises `irq_o` two edges after the write.

## Structure
- **Package `io_gpio_pkg`.** Holds the register offset localparams (REG_IN … REG_OUT_TGL) and a `reg_addr(base, ch, off, wording)` function.
- **Sub-module `io_gpio_sync`** (one per channel). Contains the SyncStages-deep synchroniser, the p flop and edge/level event generation with inputs mode, pol and arm. Its output is an event vector of data_width bits.
- **Top level.** Owns decode, registers, the arm counter and the irq OR.

## Test plan
- **Reset values.** Assert `reset_ni` low asynchronously mid-cycle → all outputs 0 immediately. Release with `gpio_i`=FF in level-high mode → STATUS stays 00 until armed, then reads FF.
- **Toggle and direction.** Write OUT ch1=A5, OUT_TGL ch1=0F → `gpio_o` ch1 = AA. Read OUT → AA with `take_controlr_o`=1. DIR=F0 → `gpio_oe_o` ch1 = F0.
- **Rising edge.** Ch0 MODE=01, POL=00, EN=01. Toggle `gpio_i[0]` 0→1 → STATUS=01 at edge SyncStages+1, `irq_o`=1 one edge later. W1C 01 → `irq_o`=0 two edges after the write.
- **Set wins over clear.** Falling edge on bit 3 (POL=08, MODE=08) coinciding with a W1C of 08 → STATUS bit 3 remains 1.
- **Level re-set and enable.** Level-high on bit 2 held at 1 with EN=0 → STATUS=04 and `irq_o`=0. W1C 04 → STATUS re-reads 04. Write EN=04 → `irq_o`=1.
- **Address edges.** Read the last channel's offset 7 and address BaseAddress + 8*NumChannels*Address_Wording → `data_o`=0 and `take_controlr_o`=0. Write IN → no change, `take_controlw_o`=0.

Source files
------------

// File: rtl/io_gpio_pkg.sv
// io_gpio_pkg: register offsets and address helper shared by the GPIO block
package io_gpio_pkg;

  localparam int REG_IN         = 0;
  localparam int REG_OUT        = 1;
  localparam int REG_DIR        = 2;
  localparam int REG_IRQ_EN     = 3;
  localparam int REG_IRQ_MODE   = 4;
  localparam int REG_IRQ_POL    = 5;
  localparam int REG_IRQ_STATUS = 6;
  localparam int REG_OUT_TGL    = 7;
  localparam int REGS_PER_CH    = 8;

  function automatic int reg_addr(input int base, input int ch, input int off, input int wording);
    return base + (ch * REGS_PER_CH + off) * wording;
  endfunction

endpackage

// File: rtl/io_gpio_sync.sv
// io_gpio_sync: per-channel input synchroniser with level/edge event generation
module io_gpio_sync #(
  parameter int data_width = 8,
  parameter int SyncStages = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [data_width-1:0] gpio_i,
  input  logic [data_width-1:0] mode_i,
  input  logic [data_width-1:0] pol_i,
  input  logic                  arm_i,
  output logic [data_width-1:0] sync_o,
  output logic [data_width-1:0] event_o
);

  logic [data_width-1:0] r_sync [SyncStages];
  logic [data_width-1:0] r_prev;
  logic [data_width-1:0] w_edge;
  logic [data_width-1:0] w_level;

  // synchroniser chain plus one extra flop holding the previous synchronised value
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < SyncStages; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SyncStages; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SyncStages-1];
    end
  end

  assign sync_o  = r_sync[SyncStages-1];
  assign w_edge  = (sync_o & ~r_prev & ~pol_i) | (~sync_o & r_prev & pol_i);
  assign w_level = sync_o ^ pol_i;
  assign event_o = arm_i ? ((w_edge & mode_i) | (w_level & ~mode_i)) : '0;

endmodule

// File: rtl/io_gpio.sv
// io_gpio: multi-channel GPIO with per-bit direction, toggle and sticky IRQ status
module io_gpio
  import io_gpio_pkg::*;
#(
  parameter int BaseAddress     = 0,
  parameter int address_width   = 16,
  parameter int data_width      = 8,
  parameter int Address_Wording = 1,
  parameter int NumChannels     = 2,
  parameter int SyncStages      = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [address_width-1:0]          address_i,
  input  logic [data_width-1:0]             data_i,
  output logic [data_width-1:0]             data_o,
  input  logic                              rd_wr_i,
  output logic                              take_controlr_o,
  output logic                              take_controlw_o,
  output logic                              irq_o,
  input  logic [NumChannels*data_width-1:0] gpio_i,
  output logic [NumChannels*data_width-1:0] gpio_o,
  output logic [NumChannels*data_width-1:0] gpio_oe_o
);

  localparam int ArmMax = SyncStages + 1;
  localparam int ArmW   = $clog2(ArmMax + 1);

  logic [data_width-1:0] r_out    [NumChannels];
  logic [data_width-1:0] r_dir    [NumChannels];
  logic [data_width-1:0] r_en     [NumChannels];
  logic [data_width-1:0] r_mode   [NumChannels];
  logic [data_width-1:0] r_pol    [NumChannels];
  logic [data_width-1:0] r_status [NumChannels];
  logic [data_width-1:0] w_in     [NumChannels];
  logic [data_width-1:0] w_event  [NumChannels];
  logic [7:0]            w_hit    [NumChannels];
  logic [data_width-1:0] w_rdata;
  logic [data_width-1:0] r_data;
  logic                  w_rhit;
  logic                  w_whit;
  logic                  w_irq;
  logic                  w_armed;
  logic                  r_take_r;
  logic                  r_take_w;
  logic                  r_irq;
  logic [ArmW-1:0]       r_arm;

  genvar c;
  generate
    for (c = 0; c < NumChannels; c++) begin : g_ch
      io_gpio_sync #(
        .data_width(data_width),
        .SyncStages(SyncStages)
      ) u_sync (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .gpio_i  (gpio_i[c*data_width +: data_width]),
        .mode_i  (r_mode[c]),
        .pol_i   (r_pol[c]),
        .arm_i   (w_armed),
        .sync_o  (w_in[c]),
        .event_o (w_event[c])
      );
      assign gpio_o[c*data_width +: data_width]    = r_out[c];
      assign gpio_oe_o[c*data_width +: data_width] = r_dir[c];
    end
  endgenerate

  // one comparator per channel register against its mapped bus address
  always_comb begin
    w_hit = '{default: '0};
    for (int ch = 0; ch < NumChannels; ch++)
      for (int r = 0; r < REGS_PER_CH; r++)
        w_hit[ch][r] = address_i == address_width'(reg_addr(BaseAddress, ch, r, Address_Wording));
  end

  // read mux, read/write claim and irq OR across all channels
  always_comb begin
    w_rdata = '0;
    w_rhit  = 1'b0;
    w_whit  = 1'b0;
    w_irq   = 1'b0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      w_rdata = w_rdata
        | (w_hit[ch][REG_IN]         ? w_in[ch]     : '0)
        | (w_hit[ch][REG_OUT]        ? r_out[ch]    : '0)
        | (w_hit[ch][REG_DIR]        ? r_dir[ch]    : '0)
        | (w_hit[ch][REG_IRQ_EN]     ? r_en[ch]     : '0)
        | (w_hit[ch][REG_IRQ_MODE]   ? r_mode[ch]   : '0)
        | (w_hit[ch][REG_IRQ_POL]    ? r_pol[ch]    : '0)
        | (w_hit[ch][REG_IRQ_STATUS] ? r_status[ch] : '0);
      w_rhit = w_rhit | (|w_hit[ch][REG_IRQ_STATUS:REG_IN]);
      w_whit = w_whit | (|w_hit[ch][REG_OUT_TGL:REG_OUT]);
      w_irq  = w_irq | (|(r_status[ch] & r_en[ch]));
    end
  end

  assign w_armed = r_arm == ArmW'(ArmMax);

  // arm counter masks events while the synchronisers fill after reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_arm <= '0;
    else if (!w_armed) r_arm <= r_arm + ArmW'(1);
  end

  // channel registers; status set takes priority over write-1-to-clear
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int ch = 0; ch < NumChannels; ch++) begin
        r_out[ch]    <= '0;
        r_dir[ch]    <= '0;
        r_en[ch]     <= '0;
        r_mode[ch]   <= '0;
        r_pol[ch]    <= '0;
        r_status[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NumChannels; ch++) begin
        if (rd_wr_i && w_hit[ch][REG_OUT]) r_out[ch] <= data_i;
        else if (rd_wr_i && w_hit[ch][REG_OUT_TGL]) r_out[ch] <= r_out[ch] ^ data_i;
        if (rd_wr_i && w_hit[ch][REG_DIR]) r_dir[ch] <= data_i;
        if (rd_wr_i && w_hit[ch][REG_IRQ_EN]) r_en[ch] <= data_i;
        if (rd_wr_i && w_hit[ch][REG_IRQ_MODE]) r_mode[ch] <= data_i;
        if (rd_wr_i && w_hit[ch][REG_IRQ_POL]) r_pol[ch] <= data_i;
        r_status[ch] <= (r_status[ch] & ~((rd_wr_i && w_hit[ch][REG_IRQ_STATUS]) ? data_i : '0)) | w_event[ch];
      end
    end
  end

  // registered bus response and interrupt
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data   <= '0;
      r_take_r <= 1'b0;
      r_take_w <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_data   <= rd_wr_i ? '0 : w_rdata;
      r_take_r <= !rd_wr_i && w_rhit;
      r_take_w <= rd_wr_i && w_whit;
      r_irq    <= w_irq;
    end
  end

  assign data_o          = r_data;
  assign take_controlr_o = r_take_r;
  assign take_controlw_o = r_take_w;
  assign irq_o           = r_irq;

endmodule

// File: tb/tb_io_gpio.sv
// tb_io_gpio: vector table, directed corner sequences and randomized run against a cycle model
module tb_io_gpio;

  localparam int BASE = 'h100;
  localparam int W    = 2;
  localparam int NC   = 2;
  localparam int S    = 2;
  localparam int DW   = 8;
  localparam logic [15:0] IDLE = 16'h0000;

  logic               clk = 1'b0;
  logic               reset_ni;
  logic [15:0]        address_i;
  logic [DW-1:0]      data_i;
  logic [DW-1:0]      data_o;
  logic               rd_wr_i;
  logic               take_controlr_o;
  logic               take_controlw_o;
  logic               irq_o;
  logic [NC*DW-1:0]   gpio_i;
  logic [NC*DW-1:0]   gpio_o;
  logic [NC*DW-1:0]   gpio_oe_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NC*DW-1:0] m_hist [S+1];
  logic [DW-1:0] m_out [NC];
  logic [DW-1:0] m_dir [NC];
  logic [DW-1:0] m_en [NC];
  logic [DW-1:0] m_mode [NC];
  logic [DW-1:0] m_pol [NC];
  logic [DW-1:0] m_status [NC];
  logic [DW-1:0] m_data;
  logic m_tr, m_tw, m_irq;
  int m_cnt;

  typedef struct {
    logic       wr;
    int         ch;
    int         off;
    logic [7:0] data;
    logic [7:0] exp;
    logic       take;
  } vec_t;

  io_gpio #(
    .BaseAddress(BASE),
    .address_width(16),
    .data_width(DW),
    .Address_Wording(W),
    .NumChannels(NC),
    .SyncStages(S)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .address_i(address_i),
    .data_i(data_i),
    .data_o(data_o),
    .rd_wr_i(rd_wr_i),
    .take_controlr_o(take_controlr_o),
    .take_controlw_o(take_controlw_o),
    .irq_o(irq_o),
    .gpio_i(gpio_i),
    .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] addr(input int ch, input int off);
    return 16'(BASE + (ch * 8 + off) * W);
  endfunction

  function automatic bit m_decode(input logic [15:0] a, output int ch, output int off);
    int d;
    ch = 0;
    off = 0;
    if (int'(a) < BASE) return 1'b0;
    d = int'(a) - BASE;
    if ((d % W) != 0 || (d / W) >= 8 * NC) return 1'b0;
    ch = (d / W) / 8;
    off = (d / W) % 8;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_reg(input int ch, input int off);
    case (off)
      0: return m_hist[S-1][ch*DW +: DW];
      1: return m_out[ch];
      2: return m_dir[ch];
      3: return m_en[ch];
      4: return m_mode[ch];
      5: return m_pol[ch];
      6: return m_status[ch];
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
    for (int c = 0; c < NC; c++) begin
      m_out[c] = 0; m_dir[c] = 0; m_en[c] = 0;
      m_mode[c] = 0; m_pol[c] = 0; m_status[c] = 0;
    end
    m_data = 0; m_tr = 0; m_tw = 0; m_irq = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] ev [NC];
    logic [DW-1:0] clr;
    int ch, off;
    bit hit;
    logic irq_n;
    hit = m_decode(address_i, ch, off);
    irq_n = 1'b0;
    for (int c = 0; c < NC; c++) irq_n = irq_n | (|(m_status[c] & m_en[c]));
    m_tr = !rd_wr_i && hit && off <= 6;
    m_tw = rd_wr_i && hit && off >= 1;
    m_data = m_tr ? m_reg(ch, off) : 8'h00;
    m_irq = irq_n;
    for (int c = 0; c < NC; c++) begin
      ev[c] = '0;
      if (m_cnt >= S + 1)
        for (int b = 0; b < DW; b++) begin
          logic sb, pb, md, pl;
          sb = m_hist[S-1][c*DW + b];
          pb = m_hist[S][c*DW + b];
          md = m_mode[c][b];
          pl = m_pol[c][b];
          ev[c][b] = md ? (pl ? (!sb && pb) : (sb && !pb)) : (sb != pl);
        end
    end
    for (int c = 0; c < NC; c++) begin
      clr = (rd_wr_i && hit && ch == c && off == 6) ? data_i : 8'h00;
      m_status[c] = (m_status[c] & ~clr) | ev[c];
    end
    if (rd_wr_i && hit)
      case (off)
        1: m_out[ch] = data_i;
        2: m_dir[ch] = data_i;
        3: m_en[ch] = data_i;
        4: m_mode[ch] = data_i;
        5: m_pol[ch] = data_i;
        7: m_out[ch] = m_out[ch] ^ data_i;
        default: ;
      endcase
    for (int k = S; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = gpio_i;
    if (m_cnt < S + 1) m_cnt++;
  endtask

  task automatic compare_all();
    logic [NC*DW-1:0] eo, eoe;
    for (int c = 0; c < NC; c++) begin
      eo[c*DW +: DW] = m_out[c];
      eoe[c*DW +: DW] = m_dir[c];
    end
    check("data_o", data_o, m_data);
    check("take_controlr_o", take_controlr_o, m_tr);
    check("take_controlw_o", take_controlw_o, m_tw);
    check("irq_o", irq_o, m_irq);
    check("gpio_o", gpio_o, eo);
    check("gpio_oe_o", gpio_oe_o, eoe);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_ni) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d);
    rd_wr_i = wr;
    address_i = a;
    data_i = d;
  endtask

  task automatic idle();
    drive(1'b0, IDLE, 8'h00);
  endtask

  task automatic wr_reg(input int ch, input int off, input logic [7:0] d, output logic t);
    drive(1'b1, addr(ch, off), d);
    step();
    t = take_controlw_o;
    idle();
  endtask

  task automatic rd_reg(input int ch, input int off, output logic [7:0] d, output logic t);
    drive(1'b0, addr(ch, off), 8'h00);
    step();
    d = data_o;
    t = take_controlr_o;
    idle();
  endtask

  initial begin
    vec_t tbl [12];
    logic [7:0] d;
    logic t;
    logic [15:0] a;
    int idx;

    reset_ni = 1'b0;
    gpio_i = '0;
    idle();
    model_reset();
    repeat (3) step();
    check("reset gpio_o", gpio_o, 0);
    check("reset irq_o", irq_o, 0);
    reset_ni = 1'b1;

    wr_reg(0, 1, 8'hFF, t);
    wr_reg(0, 2, 8'h3C, t);
    drive(1'b0, addr(0, 1), 8'h00);
    step();
    check("pre-reset data_o", data_o, 8'hFF);
    check("pre-reset take_r", take_controlr_o, 1);
    @(posedge clk);
    #3 reset_ni = 1'b0;
    #1;
    check("async data_o", data_o, 0);
    check("async take_r", take_controlr_o, 0);
    check("async take_w", take_controlw_o, 0);
    check("async irq_o", irq_o, 0);
    check("async gpio_o", gpio_o, 0);
    check("async gpio_oe_o", gpio_oe_o, 0);
    model_reset();
    idle();
    gpio_i = '1;
    step();
    reset_ni = 1'b1;
    drive(1'b0, addr(0, 6), 8'h00);
    for (int k = 1; k <= S + 3; k++) begin
      step();
      check($sformatf("arm status edge%0d", k), data_o, (k >= S + 3) ? 8'hFF : 8'h00);
    end

    gpio_i = '0;
    idle();
    repeat (S + 2) step();
    wr_reg(0, 6, 8'hFF, t);
    wr_reg(1, 6, 8'hFF, t);
    rd_reg(0, 6, d, t);
    check("status cleared", d, 8'h00);

    tbl[0]  = '{1'b1, 0, 1, 8'h3C, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 0, 1, 8'h00, 8'h3C, 1'b1};
    tbl[2]  = '{1'b1, 0, 7, 8'hFF, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 0, 1, 8'h00, 8'hC3, 1'b1};
    tbl[4]  = '{1'b1, 0, 2, 8'h81, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 0, 2, 8'h00, 8'h81, 1'b1};
    tbl[6]  = '{1'b1, 0, 0, 8'h55, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 0, 0, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 1, 7, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1, 3, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 1, 3, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 0, 5, 8'h00, 8'h00, 1'b1};
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr_reg(tbl[i].ch, tbl[i].off, tbl[i].data, t);
        check($sformatf("tbl%0d take_w", i), t, tbl[i].take);
      end else begin
        rd_reg(tbl[i].ch, tbl[i].off, d, t);
        check($sformatf("tbl%0d data", i), d, tbl[i].exp);
        check($sformatf("tbl%0d take_r", i), t, tbl[i].take);
      end
    end

    wr_reg(1, 1, 8'hA5, t);
    check("out write take_w", t, 1);
    wr_reg(1, 7, 8'h0F, t);
    check("toggle take_w", t, 1);
    check("toggle gpio_o ch1", gpio_o[15:8], 8'hAA);
    rd_reg(1, 1, d, t);
    check("toggle read out", d, 8'hAA);
    check("toggle read take_r", t, 1);
    wr_reg(1, 2, 8'hF0, t);
    check("dir gpio_oe_o ch1", gpio_oe_o[15:8], 8'hF0);

    wr_reg(0, 4, 8'h01, t);
    wr_reg(0, 5, 8'h00, t);
    wr_reg(0, 3, 8'h01, t);
    drive(1'b0, addr(0, 6), 8'h00);
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      step();
      check($sformatf("rise irq edge%0d", k), irq_o, (k >= S + 2) ? 1 : 0);
      check($sformatf("rise status edge%0d", k), data_o, (k >= S + 2) ? 8'h01 : 8'h00);
    end
    wr_reg(0, 6, 8'h01, t);
    check("w1c irq hold", irq_o, 1);
    step();
    check("w1c irq drop", irq_o, 0);

    gpio_i[3] = 1'b1;
    wr_reg(0, 4, 8'h08, t);
    wr_reg(0, 5, 8'h08, t);
    repeat (S + 2) step();
    wr_reg(0, 6, 8'h08, t);
    rd_reg(0, 6, d, t);
    check("pre-fall status b3", d & 8'h08, 8'h00);
    gpio_i[3] = 1'b0;
    repeat (S) step();
    wr_reg(0, 6, 8'h08, t);
    rd_reg(0, 6, d, t);
    check("set wins b3", d & 8'h08, 8'h08);

    wr_reg(0, 3, 8'h00, t);
    gpio_i[10] = 1'b1;
    repeat (S + 2) step();
    rd_reg(1, 6, d, t);
    check("level status ch1", d, 8'h04);
    check("level irq disabled", irq_o, 0);
    wr_reg(1, 6, 8'h04, t);
    rd_reg(1, 6, d, t);
    check("level re-set ch1", d, 8'h04);
    wr_reg(1, 3, 8'h04, t);
    check("enable irq edge1", irq_o, 0);
    step();
    check("enable irq edge2", irq_o, 1);

    rd_reg(NC - 1, 7, d, t);
    check("tgl read data", d, 8'h00);
    check("tgl read take_r", t, 0);
    drive(1'b0, 16'(BASE + 8 * NC * W), 8'h00);
    step();
    check("past end data", data_o, 8'h00);
    check("past end take_r", take_controlr_o, 0);
    drive(1'b0, 16'(BASE + 1), 8'h00);
    step();
    check("misaligned take_r", take_controlr_o, 0);
    wr_reg(0, 0, 8'hFF, t);
    check("write IN take_w", t, 0);
    rd_reg(0, 0, d, t);
    check("IN unchanged", d, 8'h01);
    drive(1'b1, 16'(BASE + 8 * NC * W), 8'hFF);
    step();
    check("undecoded write take_w", take_controlw_o, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, NC * DW - 1);
        gpio_i[idx] = ~gpio_i[idx];
      end
      a = ($urandom_range(0, 3) != 0) ? addr($urandom_range(0, NC - 1), $urandom_range(0, 7))
                                      : 16'($urandom_range(0, 'h13F));
      drive(1'($urandom_range(0, 1)), a, 8'($urandom));
      step();
    end
    idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
